// File: rtl/router_pkg.sv
// Shared router types: tile transaction layout, arbitration mode codes, grant FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package router_pkg;

    // Arbitration mode encodings for fifo_rr_arb
    localparam int ARB_MODE_FIXED = 0;
    localparam int ARB_MODE_RR    = 1;

    // One tile transaction as carried through the per-client FIFOs
    typedef struct packed {
        logic [3:0]  dest;
        logic [3:0]  src;
        logic [1:0]  kind;
        logic [15:0] payload;
    } t_tile_trans;

    // Grant FSM: IDLE lets the arbiter choose freely, LOCKED holds the presented winner
    typedef enum logic {
        GNT_IDLE   = 1'b0,
        GNT_LOCKED = 1'b1
    } t_gnt_state;

endpackage

// File: rtl/fifo_rr_arb_fifo.sv
// Generic single-clock FIFO with occupancy count and registered storage.
// Latency: a push is visible at head_dat the cycle after it is accepted.
// Backpressure: push_rdy low while full; pushes offered while full are dropped with no state change.
module fifo_rr_arb_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign push_rdy = (count_q != CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop && !empty;

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and count registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/fifo_rr_arb.sv
// Per-client FIFOs feeding a fixed-priority or round-robin arbiter with a locked grant.
// Latency: push into an empty FIFO with no lock appears on winner_valid one cycle later.
// Backpressure: winner_ready low locks winner_id/winner_req; full client FIFOs drop pushes (in_ready low).
module fifo_rr_arb
    import router_pkg::*;
#(
    parameter  int NUM_CLIENTS = 4,
    parameter  int FIFO_DEPTH  = 4,
    parameter  int ARB_MODE    = ARB_MODE_RR,
    localparam int ID_W        = $clog2(NUM_CLIENTS),
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic        [NUM_CLIENTS-1:0]          in_valid,
    input  t_tile_trans [NUM_CLIENTS-1:0]          in_req,
    output logic        [NUM_CLIENTS-1:0]          in_ready,
    output t_tile_trans                            winner_req,
    output logic                                   winner_valid,
    input  logic                                   winner_ready,
    output logic        [ID_W-1:0]                 winner_id,
    output logic        [NUM_CLIENTS-1:0][CNT_W-1:0] fifo_count
);

    logic        [NUM_CLIENTS-1:0]            fifo_rdy;
    logic        [NUM_CLIENTS-1:0]            fifo_empty;
    logic        [NUM_CLIENTS-1:0]            pop_vec;
    logic        [NUM_CLIENTS-1:0][CNT_W-1:0] fifo_cnt;
    t_tile_trans [NUM_CLIENTS-1:0]            head_dat;

    t_gnt_state       state_q, state_d;
    logic [ID_W-1:0]  lock_id_q;
    logic [ID_W-1:0]  last_grant_q;
    logic [ID_W-1:0]  arb_sel;
    logic             arb_any;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_vld;
    logic             xfer;
    int               idx;

    // A transfer needs the gated valid, so nothing pops while reset is asserted
    assign xfer = winner_valid && winner_ready;

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_client
        assign pop_vec[g] = xfer && (winner_id == ID_W'(g));

        fifo_rr_arb_fifo #(
            .WIDTH (($bits(t_tile_trans))),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push_vld (in_valid[g]),
            .push_dat (in_req[g]),
            .push_rdy (fifo_rdy[g]),
            .pop      (pop_vec[g]),
            .head_dat (head_dat[g]),
            .empty    (fifo_empty[g]),
            .count    (fifo_cnt[g])
        );
    end

    // Arbiter: fixed scans down so client 0 wins; RR scans down from farthest so (last+1) wins
    always_comb begin
        arb_sel = '0;
        arb_any = 1'b0;
        idx     = 0;
        if (ARB_MODE == ARB_MODE_FIXED) begin
            for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
                if (!fifo_empty[i]) begin
                    arb_sel = ID_W'(i);
                    arb_any = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_CLIENTS; k >= 1; k--) begin
                idx = (int'(last_grant_q) + k) % NUM_CLIENTS;
                if (!fifo_empty[idx]) begin
                    arb_sel = ID_W'(idx);
                    arb_any = 1'b1;
                end
            end
        end
    end

    // Grant FSM state, held grant index and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= GNT_IDLE;
            lock_id_q    <= '0;
            last_grant_q <= ID_W'(NUM_CLIENTS - 1);
        end else begin
            state_q   <= state_d;
            lock_id_q <= gnt_id;
            if (xfer) begin
                last_grant_q <= winner_id;
            end
        end
    end

    // Grant FSM next state: lock when the winner is stalled, release on acceptance
    always_comb begin
        state_d = state_q;
        case (state_q)
            GNT_IDLE:   if (gnt_vld && !winner_ready) state_d = GNT_LOCKED;
            GNT_LOCKED: if (winner_ready)             state_d = GNT_IDLE;
            default:    state_d = GNT_IDLE;
        endcase
    end

    // Grant FSM outputs: a held grant overrides the arbiter's fresh choice
    always_comb begin
        if (state_q == GNT_LOCKED) begin
            gnt_id  = lock_id_q;
            gnt_vld = !fifo_empty[lock_id_q];
        end else begin
            gnt_id  = arb_sel;
            gnt_vld = arb_any;
        end
    end

    // Port drive; reset forces the idle values regardless of registered state
    always_comb begin
        winner_valid = rst && gnt_vld;
        winner_id    = rst ? gnt_id : '0;
        winner_req   = winner_valid ? head_dat[gnt_id] : '0;
        in_ready     = rst ? fifo_rdy : '1;
        fifo_count   = rst ? fifo_cnt : '0;
    end

endmodule

// File: tb/tb_fifo_rr_arb.sv
module tb_fifo_rr_arb;
    import router_pkg::*;

    typedef struct packed {
        logic [1:0]  id;
        t_tile_trans req;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [3:0]            in_valid;
    t_tile_trans [3:0]     in_req;
    logic                  winner_ready;

    logic [3:0]            rr_in_ready, fp_in_ready;
    t_tile_trans           rr_winner_req, fp_winner_req;
    logic                  rr_winner_valid, fp_winner_valid;
    logic [1:0]            rr_winner_id, fp_winner_id;
    logic [3:0][2:0]       rr_fifo_count, fp_fifo_count;

    exp_t rr_q[$];
    exp_t fp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_rr_arb #(.NUM_CLIENTS(4), .FIFO_DEPTH(4), .ARB_MODE(ARB_MODE_RR)) dut_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_req(in_req), .in_ready(rr_in_ready),
        .winner_req(rr_winner_req), .winner_valid(rr_winner_valid), .winner_ready(winner_ready),
        .winner_id(rr_winner_id), .fifo_count(rr_fifo_count)
    );

    fifo_rr_arb #(.NUM_CLIENTS(4), .FIFO_DEPTH(4), .ARB_MODE(ARB_MODE_FIXED)) dut_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_req(in_req), .in_ready(fp_in_ready),
        .winner_req(fp_winner_req), .winner_valid(fp_winner_valid), .winner_ready(winner_ready),
        .winner_id(fp_winner_id), .fifo_count(fp_fifo_count)
    );

    function automatic t_tile_trans mk(input int c, input int e);
        t_tile_trans t;
        t.dest    = 4'(c + 8);
        t.src     = 4'(c);
        t.kind    = 2'(e);
        t.payload = 16'(16'hA000 + c * 16'h0100 + e);
        return t;
    endfunction

    function automatic exp_t mk_exp(input int c, input int e);
        exp_t x;
        x.id  = 2'(c);
        x.req = mk(c, e);
        return x;
    endfunction

    task automatic do_reset();
        rst          = 1'b0;
        in_valid     = '0;
        in_req       = '0;
        winner_ready = 1'b0;
        rr_q.delete();
        fp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        in_valid     = '0;
        in_req       = '0;
        winner_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rr_in_ready !== 4'hF || fp_in_ready !== 4'hF) begin
            errors++; $display("FAIL reset_in_ready: got %h/%h want f", rr_in_ready, fp_in_ready);
        end
        checks++;
        if (rr_winner_valid !== 1'b0 || rr_winner_id !== 2'd0 || rr_winner_req !== '0) begin
            errors++; $display("FAIL reset_winner: valid %b id %0d req %h want 0 0 0", rr_winner_valid, rr_winner_id, rr_winner_req);
        end
        checks++;
        if (rr_fifo_count !== '0 || fp_fifo_count !== '0) begin
            errors++; $display("FAIL reset_count: got %h/%h want 0", rr_fifo_count, fp_fifo_count);
        end
        rst = 1'b1;
    endtask

    task automatic test_single();
        exp_t e;
        do_reset();
        in_valid  = 4'b0100;
        in_req[2] = mk(2, 0);
        rr_q.push_back(mk_exp(2, 0));
        @(negedge clk);
        in_valid = '0;
        checks++;
        if (rr_winner_valid !== 1'b1 || rr_winner_id !== 2'd2) begin
            errors++; $display("FAIL single_latency: valid %b id %0d want 1 2", rr_winner_valid, rr_winner_id);
        end
        winner_ready = 1'b1;
        for (int c = 0; c < 20 && rr_q.size() > 0; c++) begin
            if (rr_winner_valid && winner_ready) begin
                e = rr_q.pop_front();
                checks++;
                if (rr_winner_id !== e.id || rr_winner_req !== e.req) begin
                    errors++; $display("FAIL single_xfer: id %0d req %h want %0d %h", rr_winner_id, rr_winner_req, e.id, e.req);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (rr_q.size() != 0) begin
            errors++; $display("FAIL single_timeout: %0d left want 0", rr_q.size());
        end
        checks++;
        if (rr_fifo_count[2] !== 3'd0 || rr_winner_valid !== 1'b0 || rr_winner_req !== '0) begin
            errors++; $display("FAIL single_after: count %0d valid %b req %h want 0 0 0", rr_fifo_count[2], rr_winner_valid, rr_winner_req);
        end
    endtask

    task automatic test_rr_order();
        exp_t e;
        do_reset();
        in_valid = 4'hF;
        for (int c = 0; c < 4; c++) in_req[c] = mk(c, 0);
        @(negedge clk);
        for (int c = 0; c < 4; c++) in_req[c] = mk(c, 1);
        @(negedge clk);
        in_valid = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) rr_q.push_back(mk_exp(c, r));
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (rr_fifo_count[c] !== 3'd2) begin
                errors++; $display("FAIL rr_fill[%0d]: got %0d want 2", c, rr_fifo_count[c]);
            end
        end
        winner_ready = 1'b1;
        for (int c = 0; c < 40 && rr_q.size() > 0; c++) begin
            if (rr_winner_valid && winner_ready) begin
                e = rr_q.pop_front();
                checks++;
                if (rr_winner_id !== e.id || rr_winner_req !== e.req) begin
                    errors++; $display("FAIL rr_order: id %0d req %h want %0d %h", rr_winner_id, rr_winner_req, e.id, e.req);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (rr_q.size() != 0 || rr_winner_valid !== 1'b0) begin
            errors++; $display("FAIL rr_done: left %0d valid %b want 0 0", rr_q.size(), rr_winner_valid);
        end
    endtask

    task automatic test_lock();
        exp_t e;
        do_reset();
        in_valid  = 4'b0010;
        in_req[1] = mk(1, 7);
        rr_q.push_back(mk_exp(1, 7));
        @(negedge clk);
        in_valid  = 4'b0001;
        in_req[0] = mk(0, 0);
        rr_q.push_back(mk_exp(0, 0));
        checks++;
        if (rr_winner_valid !== 1'b1 || rr_winner_id !== 2'd1) begin
            errors++; $display("FAIL lock_first: valid %b id %0d want 1 1", rr_winner_valid, rr_winner_id);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = '0;
            checks++;
            if (rr_winner_valid !== 1'b1 || rr_winner_id !== 2'd1 || rr_winner_req !== mk(1, 7)) begin
                errors++; $display("FAIL lock_hold[%0d]: valid %b id %0d req %h want 1 1 %h", k, rr_winner_valid, rr_winner_id, rr_winner_req, mk(1, 7));
            end
        end
        winner_ready = 1'b1;
        for (int c = 0; c < 20 && rr_q.size() > 0; c++) begin
            if (rr_winner_valid && winner_ready) begin
                e = rr_q.pop_front();
                checks++;
                if (rr_winner_id !== e.id || rr_winner_req !== e.req) begin
                    errors++; $display("FAIL lock_xfer: id %0d req %h want %0d %h", rr_winner_id, rr_winner_req, e.id, e.req);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (rr_q.size() != 0) begin
            errors++; $display("FAIL lock_timeout: %0d left want 0", rr_q.size());
        end
    endtask

    task automatic test_full();
        exp_t e;
        do_reset();
        in_valid  = 4'b1000;
        in_req[3] = mk(3, 0);
        for (int p = 1; p <= 5; p++) begin
            @(negedge clk);
            checks++;
            if (rr_fifo_count[3] !== 3'((p < 4) ? p : 4) || rr_in_ready[3] !== (p < 4)) begin
                errors++; $display("FAIL full_push[%0d]: count %0d rdy %b want %0d %b", p, rr_fifo_count[3], rr_in_ready[3], (p < 4) ? p : 4, p < 4);
            end
            if (p < 5) in_req[3] = mk(3, p);
            else       in_valid  = '0;
        end
        for (int k = 0; k < 4; k++) rr_q.push_back(mk_exp(3, k));
        in_valid     = 4'b1000;
        in_req[3]    = mk(3, 9);
        winner_ready = 1'b1;
        e = rr_q.pop_front();
        checks++;
        if (rr_winner_valid !== 1'b1 || rr_winner_id !== e.id || rr_winner_req !== e.req) begin
            errors++; $display("FAIL full_head: valid %b id %0d req %h want 1 %0d %h", rr_winner_valid, rr_winner_id, rr_winner_req, e.id, e.req);
        end
        @(negedge clk);
        in_valid = '0;
        checks++;
        if (rr_fifo_count[3] !== 3'd3 || rr_in_ready[3] !== 1'b1) begin
            errors++; $display("FAIL full_pushpop: count %0d rdy %b want 3 1", rr_fifo_count[3], rr_in_ready[3]);
        end
        for (int c = 0; c < 20 && rr_q.size() > 0; c++) begin
            if (rr_winner_valid && winner_ready) begin
                e = rr_q.pop_front();
                checks++;
                if (rr_winner_id !== e.id || rr_winner_req !== e.req) begin
                    errors++; $display("FAIL full_drain: id %0d req %h want %0d %h", rr_winner_id, rr_winner_req, e.id, e.req);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (rr_q.size() != 0 || rr_fifo_count[3] !== 3'd0 || rr_winner_valid !== 1'b0) begin
            errors++; $display("FAIL full_done: left %0d count %0d valid %b want 0 0 0", rr_q.size(), rr_fifo_count[3], rr_winner_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        in_valid  = 4'b0010;
        in_req[1] = mk(1, 0);
        rr_q.push_back(mk_exp(1, 0));
        @(negedge clk);
        in_req[1] = mk(1, 1);
        rr_q.push_back(mk_exp(1, 1));
        winner_ready = 1'b1;
        e = rr_q.pop_front();
        checks++;
        if (rr_winner_valid !== 1'b1 || rr_winner_id !== e.id || rr_winner_req !== e.req) begin
            errors++; $display("FAIL b2b_first: valid %b id %0d req %h want 1 %0d %h", rr_winner_valid, rr_winner_id, rr_winner_req, e.id, e.req);
        end
        @(negedge clk);
        in_valid = '0;
        e = rr_q.pop_front();
        checks++;
        if (rr_fifo_count[1] !== 3'd1 || rr_winner_valid !== 1'b1 || rr_winner_id !== e.id || rr_winner_req !== e.req) begin
            errors++; $display("FAIL b2b_second: count %0d valid %b id %0d req %h want 1 1 %0d %h", rr_fifo_count[1], rr_winner_valid, rr_winner_id, rr_winner_req, e.id, e.req);
        end
        @(negedge clk);
        checks++;
        if (rr_fifo_count[1] !== 3'd0 || rr_winner_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_empty: count %0d valid %b want 0 0", rr_fifo_count[1], rr_winner_valid);
        end
    endtask

    task automatic test_fixed();
        exp_t e;
        do_reset();
        in_valid = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            in_req[0] = mk(0, k);
            in_req[2] = mk(2, k);
            @(negedge clk);
        end
        in_valid = '0;
        for (int k = 0; k < 3; k++) fp_q.push_back(mk_exp(0, k));
        for (int k = 0; k < 3; k++) fp_q.push_back(mk_exp(2, k));
        checks++;
        if (fp_fifo_count[0] !== 3'd3 || fp_fifo_count[2] !== 3'd3) begin
            errors++; $display("FAIL fixed_fill: counts %0d %0d want 3 3", fp_fifo_count[0], fp_fifo_count[2]);
        end
        winner_ready = 1'b1;
        for (int c = 0; c < 30 && fp_q.size() > 0; c++) begin
            if (fp_winner_valid && winner_ready) begin
                e = fp_q.pop_front();
                checks++;
                if (fp_winner_id !== e.id || fp_winner_req !== e.req) begin
                    errors++; $display("FAIL fixed_order: id %0d req %h want %0d %h", fp_winner_id, fp_winner_req, e.id, e.req);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (fp_q.size() != 0 || fp_winner_valid !== 1'b0) begin
            errors++; $display("FAIL fixed_done: left %0d valid %b want 0 0", fp_q.size(), fp_winner_valid);
        end
    endtask

    task automatic test_reset_locked();
        do_reset();
        in_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) in_req[c] = mk(c, k);
            @(negedge clk);
        end
        in_valid = '0;
        @(negedge clk);
        checks++;
        if (rr_in_ready !== 4'h0 || rr_winner_valid !== 1'b1 || rr_fifo_count !== {4{3'd4}}) begin
            errors++; $display("FAIL rstlk_full: rdy %h valid %b counts %h want 0 1 924", rr_in_ready, rr_winner_valid, rr_fifo_count);
        end
        rst          = 1'b0;
        winner_ready = 1'b1;
        #1;
        checks++;
        if (rr_winner_valid !== 1'b0 || rr_in_ready !== 4'hF || rr_winner_id !== 2'd0 || rr_winner_req !== '0) begin
            errors++; $display("FAIL rstlk_during: valid %b rdy %h id %0d req %h want 0 f 0 0", rr_winner_valid, rr_in_ready, rr_winner_id, rr_winner_req);
        end
        @(negedge clk);
        checks++;
        if (rr_winner_valid !== 1'b0 || rr_in_ready !== 4'hF || rr_fifo_count !== '0) begin
            errors++; $display("FAIL rstlk_next: valid %b rdy %h counts %h want 0 f 0", rr_winner_valid, rr_in_ready, rr_fifo_count);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rr_winner_valid !== 1'b0 || rr_in_ready !== 4'hF || rr_fifo_count !== '0 || fp_fifo_count !== '0) begin
            errors++; $display("FAIL rstlk_after: valid %b rdy %h counts %h/%h want 0 f 0 0", rr_winner_valid, rr_in_ready, rr_fifo_count, fp_fifo_count);
        end
        winner_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_order();
        test_lock();
        test_full();
        test_back_to_back();
        test_fixed();
        test_reset_locked();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_rr_arb.md
FIFO_RR_ARB -- requirements
Module: fifo_rr_arb

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 4: number of input channels, 2..16.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: entries per client FIFO, power of two, 2..32.
REQ-003 SHALL have parameter ARB_MODE, default 1: 0 = fixed priority (client 0 highest), 1 = round-robin.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-low reset; rst==0 at a clk edge resets the block.
REQ-006 SHALL have port in_valid  input  NUM_CLIENTS  per-client push request.
REQ-007 SHALL have port in_req  input  NUM_CLIENTS x t_tile_trans  per-client transaction.
REQ-008 SHALL have port in_ready  output  NUM_CLIENTS  per-client FIFO not full.
REQ-009 SHALL have port winner_req  output  t_tile_trans  granted transaction.
REQ-010 SHALL have port winner_valid  output  1  a granted transaction is presented.
REQ-011 SHALL have port winner_ready  input  1  downstream accepts winner_req this cycle.
REQ-012 SHALL have port winner_id  output  $clog2(NUM_CLIENTS)  index of the granted client.
REQ-013 SHALL have port fifo_count  output  NUM_CLIENTS x $clog2(FIFO_DEPTH+1)  per-client occupancy.

Function
REQ-014 SHALL push client i when in_valid[i] && in_ready[i]; in_ready[i] = (count[i] != FIFO_DEPTH).
REQ-015 SHALL drop, without any state change, a push offered while in_ready[i]==0, including a same-cycle pop on a full FIFO.
REQ-016 SHALL accept a same-cycle push and pop on a non-full FIFO, leaving count unchanged.
REQ-017 SHALL have a push-to-winner_valid latency of 1 cycle when the FIFO is empty and no grant is locked.
REQ-018 SHALL assert winner_valid whenever any FIFO is non-empty; winner_req is the head of FIFO winner_id.
REQ-019 SHALL complete a transfer, popping FIFO winner_id, only when winner_valid && winner_ready.
REQ-020 SHALL lock the grant: while winner_valid && !winner_ready, winner_id and winner_req stay stable across cycles.
REQ-021 SHALL in ARB_MODE 1 search from (last_grant+1) mod NUM_CLIENTS upward, wrapping; last_grant updates only on a completed transfer.
REQ-022 SHALL in ARB_MODE 0 select the lowest-index non-empty FIFO, subject to REQ-020.
REQ-023 SHALL support back-to-back transfers, one per cycle, while winner_ready stays high.
REQ-024 SHALL drive winner_req to all-zero when winner_valid is 0.
REQ-025 SHALL implement a two-state grant FSM: IDLE (no lock) -> LOCKED on winner_valid && !winner_ready; LOCKED -> IDLE on winner_ready.

Reset
REQ-026 SHALL, while rst==0, clear all FIFO pointers and counts, set last_grant = NUM_CLIENTS-1, and set the FSM to IDLE.
REQ-027 SHALL hold outputs during reset at: in_ready all 1, winner_valid 0, winner_id 0, winner_req 0, fifo_count all 0.
REQ-028 SHALL discard FIFO contents and any held grant when reset is asserted mid-transfer; no transfer completes in a reset cycle.

Structure
REQ-029 SHALL take t_tile_trans from router_pkg; the arbitration-mode encodings SHALL be localparams in router_pkg.
REQ-030 SHALL instantiate the existing fifo sub-module once per client via generate; the arbiter logic SHALL be in this module.
REQ-031 SHALL keep combinational paths from winner_ready to in_ready out of the design.

Verification
REQ-032 SHALL cover: reset, then a push on client 2 only -> winner_valid=1 and winner_id=2 one cycle later, and fifo_count[2]=0 after the pop.
REQ-033 SHALL cover: ARB_MODE=1, all 4 clients holding 2 entries, winner_ready=1 -> winner_id sequence 0,1,2,3,0,1,2,3, then winner_valid=0.
REQ-034 SHALL cover: winner_ready=0 for 5 cycles with client 1 granted while client 0 is pushed -> winner_id stays 1 and winner_req stays constant until winner_ready rises.
REQ-035 SHALL cover: FIFO_DEPTH=4, 5 pushes on client 3 with no pops -> in_ready[3]=0 after the 4th push, the 5th push is dropped, and fifo_count[3]=4.
REQ-036 SHALL cover: ARB_MODE=0, clients 0 and 2 continuously non-empty -> only client 0 wins until its FIFO empties.
REQ-037 SHALL cover: rst driven to 0 while in LOCKED with full FIFOs -> next cycle winner_valid=0, all in_ready=1, and all fifo_count=0.
